// File: rtl/classify_pkg.sv
// Shared types and constants for the spike classification output stage.
package classify_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_DECIDE,
        ST_HOLD
    } state_e;

    localparam logic CLASS0        = 1'b0;
    localparam logic CLASS1        = 1'b1;
    localparam int   POT_W_DEFAULT = 3;

endpackage

// File: rtl/spike_count_ext.sv
// Extends a narrow free-running wrap-around spike counter into a wide
// saturating count relative to a baseline captured on clear.
module spike_count_ext
    import classify_pkg::*;
#(
    parameter int POT_W = POT_W_DEFAULT,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             track,
    input  logic [POT_W-1:0] potential,
    output logic [CNT_W-1:0] count
);

    localparam int SUM_W = CNT_W + 1;

    logic [POT_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [POT_W-1:0] delta;
    logic [SUM_W-1:0] sum;

    always_comb begin
        prev_d  = prev_q;
        count_d = count_q;
        // Modular subtraction turns an upstream 7->0 wrap into a delta of 1.
        delta   = potential - prev_q;
        sum     = {1'b0, count_q} + SUM_W'(delta);
        if (clear) begin
            prev_d  = potential;
            count_d = '0;
        end else if (track) begin
            prev_d  = potential;
            count_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            count_q <= '0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spike_class_decider.sv
// Gates the output-neuron counter stage for a fixed window of timesteps and
// declares the class whose extended spike count is larger.
module spike_class_decider
    import classify_pkg::*;
#(
    parameter int POT_W     = POT_W_DEFAULT,
    parameter int CNT_W     = 8,
    parameter int WINDOW    = 64,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ts_tick,
    input  logic [POT_W-1:0] potential1_u,
    input  logic [POT_W-1:0] potential2_u,
    output logic             en_u,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             class_id,
    output logic             tie,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2
);

    localparam int                TICK_W     = 16;
    localparam int                DRN_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [TICK_W-1:0] WINDOW_L   = TICK_W'(WINDOW);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               en_u_q, en_u_d;
    logic               valid_q, valid_d;
    logic               class_q, class_d;
    logic               tie_q, tie_d;
    logic               clear, track;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        drain_d = drain_q;
        valid_d = valid_q;
        class_d = class_q;
        tie_d   = tie_q;
        clear   = 1'b0;
        track   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ARM;
            end
            ST_ARM: begin
                clear   = 1'b1;
                tick_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                track = 1'b1;
                if (ts_tick) begin
                    tick_d = tick_q + 1'b1;
                    if (tick_d == WINDOW_L) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            // Spikes still in flight upstream when en_u falls land here.
            ST_DRAIN: begin
                track = 1'b1;
                if (drain_q == DRAIN_LAST) state_d = ST_DECIDE;
                else                       drain_d = drain_q + 1'b1;
            end
            ST_DECIDE: begin
                if (count1 > count2) begin
                    class_d = CLASS0;
                    tie_d   = 1'b0;
                end else if (count2 > count1) begin
                    class_d = CLASS1;
                    tie_d   = 1'b0;
                end else begin
                    class_d = CLASS0;
                    tie_d   = 1'b1;
                end
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        en_u_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            drain_q <= '0;
            en_u_q  <= 1'b0;
            valid_q <= 1'b0;
            class_q <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            drain_q <= drain_d;
            en_u_q  <= en_u_d;
            valid_q <= valid_d;
            class_q <= class_d;
            tie_q   <= tie_d;
        end
    end

    spike_count_ext #(.POT_W(POT_W), .CNT_W(CNT_W)) u_ext1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .track     (track),
        .potential (potential1_u),
        .count     (count1)
    );

    spike_count_ext #(.POT_W(POT_W), .CNT_W(CNT_W)) u_ext2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .track     (track),
        .potential (potential2_u),
        .count     (count2)
    );

    assign en_u         = en_u_q;
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = valid_q;
    assign class_id     = class_q;
    assign tie          = tie_q;

endmodule

// File: tb/tb_spike_class_decider.sv
// Directed bench for spike_class_decider; a second narrow-count instance
// shares all inputs to exercise saturation.
module tb_spike_class_decider;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, ts_tick = 1'b0, result_ready = 1'b0;
    logic [2:0] p1 = 3'd0, p2 = 3'd0;
    logic       en_u, busy, rv, class_id, tie;
    logic [7:0] count1, count2;
    logic       s_en_u, s_busy, s_rv, s_class_id, s_tie;
    logic [3:0] s_count1, s_count2;
    int         pass_cnt = 0, total_cnt = 0;

    always #5 clk = ~clk;

    spike_class_decider #(.POT_W(3), .CNT_W(8), .WINDOW(4), .DRAIN_CYC(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ts_tick(ts_tick),
        .potential1_u(p1), .potential2_u(p2), .en_u(en_u), .busy(busy),
        .result_valid(rv), .result_ready(result_ready), .class_id(class_id),
        .tie(tie), .count1(count1), .count2(count2)
    );

    spike_class_decider #(.POT_W(3), .CNT_W(4), .WINDOW(4), .DRAIN_CYC(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .ts_tick(ts_tick),
        .potential1_u(p1), .potential2_u(p2), .en_u(s_en_u), .busy(s_busy),
        .result_valid(s_rv), .result_ready(result_ready), .class_id(s_class_id),
        .tie(s_tie), .count1(s_count1), .count2(s_count2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1; step(1); start = 1'b0; step(1);
    endtask

    task automatic finish_window();
        bit ok;
        ts_tick = 1'b1; step(4); ts_tick = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rv) begin ok = 1'b1; break; end
            step(1);
        end
        total_cnt++; if (!ok) $display("FAIL window_timeout rv=%0b exp 1", rv); else pass_cnt++;
    endtask

    task automatic release_result();
        result_ready = 1'b1; step(1); result_ready = 1'b0;
        total_cnt++; if (rv !== 1'b0) $display("FAIL release_rv got %0b exp 0", rv); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL release_busy got %0b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset();
        step(2);
        total_cnt++; if ({en_u, busy, rv, class_id, tie} !== 5'b0) $display("FAIL reset_flags got %b exp 00000", {en_u, busy, rv, class_id, tie}); else pass_cnt++;
        total_cnt++; if ({count1, count2} !== 16'h0) $display("FAIL reset_counts got %0d/%0d exp 0/0", count1, count2); else pass_cnt++;
        rst_n = 1'b1; step(1);
    endtask

    task automatic test_basic();
        start = 1'b1; step(1); start = 1'b0;
        total_cnt++; if (en_u !== 1'b0) $display("FAIL basic_arm_en got %0b exp 0", en_u); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL basic_arm_busy got %0b exp 1", busy); else pass_cnt++;
        step(1);
        total_cnt++; if (en_u !== 1'b1) $display("FAIL basic_run_en got %0b exp 1", en_u); else pass_cnt++;
        p1 = 3'd1; step(1);
        p1 = 3'd2; p2 = 3'd1; step(1);
        p1 = 3'd3; step(1);
        ts_tick = 1'b1; step(4); ts_tick = 1'b0;
        total_cnt++; if (en_u !== 1'b0) $display("FAIL basic_drain_en got %0b exp 0", en_u); else pass_cnt++;
        step(3);
        total_cnt++; if (rv !== 1'b0) $display("FAIL basic_rv_early got %0b exp 0", rv); else pass_cnt++;
        step(1);
        total_cnt++; if (rv !== 1'b1) $display("FAIL basic_rv_latency got %0b exp 1", rv); else pass_cnt++;
        total_cnt++; if (count1 !== 8'd3) $display("FAIL basic_count1 got %0d exp 3", count1); else pass_cnt++;
        total_cnt++; if (count2 !== 8'd1) $display("FAIL basic_count2 got %0d exp 1", count2); else pass_cnt++;
        total_cnt++; if ({class_id, tie} !== 2'b00) $display("FAIL basic_class got %b exp 00", {class_id, tie}); else pass_cnt++;
        step(3);
        total_cnt++; if (rv !== 1'b1) $display("FAIL basic_rv_hold got %0b exp 1", rv); else pass_cnt++;
        release_result();
        total_cnt++; if (count1 !== 8'd3) $display("FAIL basic_idle_retain got %0d exp 3", count1); else pass_cnt++;
    endtask

    task automatic test_wrap();
        p1 = 3'd6; p2 = 3'd3; step(1);
        do_start();
        p1 = 3'd7; p2 = 3'd4; step(1);
        p1 = 3'd0; p2 = 3'd5; step(1);
        p1 = 3'd1; p2 = 3'd6; step(1);
        p1 = 3'd2; p2 = 3'd7; step(1);
        p2 = 3'd0; step(1);
        finish_window();
        total_cnt++; if (count1 !== 8'd4) $display("FAIL wrap_count1 got %0d exp 4", count1); else pass_cnt++;
        total_cnt++; if (count2 !== 8'd5) $display("FAIL wrap_count2 got %0d exp 5", count2); else pass_cnt++;
        total_cnt++; if ({class_id, tie} !== 2'b10) $display("FAIL wrap_class got %b exp 10", {class_id, tie}); else pass_cnt++;
        release_result();
    endtask

    task automatic test_zero_tie();
        do_start();
        finish_window();
        total_cnt++; if ({count1, count2} !== 16'h0) $display("FAIL zero_counts got %0d/%0d exp 0/0", count1, count2); else pass_cnt++;
        total_cnt++; if ({class_id, tie} !== 2'b01) $display("FAIL zero_tie got %b exp 01", {class_id, tie}); else pass_cnt++;
        release_result();
    endtask

    task automatic test_late();
        do_start();
        ts_tick = 1'b1; step(4); ts_tick = 1'b0;
        total_cnt++; if (en_u !== 1'b0) $display("FAIL late_en got %0b exp 0", en_u); else pass_cnt++;
        step(2);
        p2 = p2 + 3'd1; step(1);
        p2 = p2 + 3'd1; step(1);
        total_cnt++; if (rv !== 1'b1) $display("FAIL late_rv got %0b exp 1", rv); else pass_cnt++;
        p2 = p2 + 3'd1; step(1);
        total_cnt++; if (count2 !== 8'd1) $display("FAIL late_count2 got %0d exp 1", count2); else pass_cnt++;
        total_cnt++; if (count1 !== 8'd0) $display("FAIL late_count1 got %0d exp 0", count1); else pass_cnt++;
        total_cnt++; if ({class_id, tie} !== 2'b10) $display("FAIL late_class got %b exp 10", {class_id, tie}); else pass_cnt++;
        release_result();
    endtask

    task automatic test_saturate();
        do_start();
        for (int i = 0; i < 20; i++) begin
            p1 = p1 + 3'd1;
            if (i < 5) p2 = p2 + 3'd1;
            step(1);
        end
        finish_window();
        total_cnt++; if (count1 !== 8'd20) $display("FAIL sat_wide_count1 got %0d exp 20", count1); else pass_cnt++;
        total_cnt++; if (s_count1 !== 4'd15) $display("FAIL sat_narrow_count1 got %0d exp 15", s_count1); else pass_cnt++;
        total_cnt++; if (s_count2 !== 4'd5) $display("FAIL sat_narrow_count2 got %0d exp 5", s_count2); else pass_cnt++;
        total_cnt++; if ({s_class_id, s_tie} !== 2'b00) $display("FAIL sat_narrow_class got %b exp 00", {s_class_id, s_tie}); else pass_cnt++;
        total_cnt++; if ({class_id, tie} !== 2'b00) $display("FAIL sat_wide_class got %b exp 00", {class_id, tie}); else pass_cnt++;
        release_result();
        do_start();
        for (int i = 0; i < 5; i++) begin
            p1 = p1 + 3'd1; p2 = p2 + 3'd1; step(1);
        end
        finish_window();
        total_cnt++; if ({count1, count2} !== {8'd5, 8'd5}) $display("FAIL tie_counts got %0d/%0d exp 5/5", count1, count2); else pass_cnt++;
        total_cnt++; if ({class_id, tie} !== 2'b01) $display("FAIL tie_class got %b exp 01", {class_id, tie}); else pass_cnt++;
        release_result();
    endtask

    task automatic test_protocol();
        do_start();
        p1 = p1 + 3'd1; step(1);
        p1 = p1 + 3'd1; step(1);
        start = 1'b1; step(1); start = 1'b0;
        total_cnt++; if ({en_u, busy} !== 2'b11) $display("FAIL proto_run_start got %b exp 11", {en_u, busy}); else pass_cnt++;
        finish_window();
        total_cnt++; if (count1 !== 8'd2) $display("FAIL proto_count1 got %0d exp 2", count1); else pass_cnt++;
        start = 1'b1; step(1); start = 1'b0;
        total_cnt++; if ({rv, busy} !== 2'b11) $display("FAIL proto_hold_start got %b exp 11", {rv, busy}); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            step(1);
            total_cnt++;
            if ({rv, class_id, tie, count1, count2} !== {3'b100, 8'd2, 8'd0})
                $display("FAIL proto_stable cyc%0d got rv=%0b cls=%0b tie=%0b c=%0d/%0d exp 1 0 0 2/0", i, rv, class_id, tie, count1, count2);
            else pass_cnt++;
        end
        result_ready = 1'b1; start = 1'b1; step(1); result_ready = 1'b0; start = 1'b0;
        total_cnt++; if ({rv, busy} !== 2'b00) $display("FAIL proto_ready_start got %b exp 00", {rv, busy}); else pass_cnt++;
        step(3);
        total_cnt++; if ({busy, en_u} !== 2'b00) $display("FAIL proto_no_rerun got %b exp 00", {busy, en_u}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_start();
        p1 = p1 + 3'd1; step(1);
        rst_n = 1'b0; #1;
        total_cnt++; if ({en_u, busy, rv, class_id, tie} !== 5'b0) $display("FAIL rstmid_flags got %b exp 00000", {en_u, busy, rv, class_id, tie}); else pass_cnt++;
        total_cnt++; if ({count1, count2} !== 16'h0) $display("FAIL rstmid_counts got %0d/%0d exp 0/0", count1, count2); else pass_cnt++;
        step(1); rst_n = 1'b1; step(1);
        do_start();
        for (int i = 0; i < 3; i++) begin
            p2 = p2 + 3'd1; step(1);
        end
        finish_window();
        total_cnt++; if ({count1, count2} !== {8'd0, 8'd3}) $display("FAIL rstmid_rerun_counts got %0d/%0d exp 0/3", count1, count2); else pass_cnt++;
        total_cnt++; if ({class_id, tie} !== 2'b10) $display("FAIL rstmid_rerun_class got %b exp 10", {class_id, tie}); else pass_cnt++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_tie();
        test_late();
        test_saturate();
        test_protocol();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
